// File: rtl/reset_supervisor_pkg.sv
// rtl/reset_supervisor_pkg.sv - shared state encoding, log-entry layout and defaults
// The entry packer lives here so the log format is defined in one place.
package reset_supervisor_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2,
    ST_SAFE   = 2'd3
  } sup_state_e;

  localparam int LOG_W            = 16;
  localparam int LOG_TS_LSB       = 0;
  localparam int LOG_TS_W         = 10;
  localparam int LOG_RSTOUT_BIT   = 10;
  localparam int LOG_WDFAIL_BIT   = 11;
  localparam int LOG_BROWNOUT_BIT = 12;
  localparam int LOG_FLSTAT_LSB   = 13;
  localparam int LOG_FLSTAT_W     = 3;

  localparam int DEF_STRETCH   = 16;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_ESC_LIMIT = 3;
  localparam int DEF_QUIET     = 64;

  function automatic logic [LOG_W-1:0] pack_entry(
    input logic [LOG_FLSTAT_W-1:0] flstat,
    input logic                    brownout,
    input logic                    wdfail,
    input logic                    rstout,
    input logic [LOG_TS_W-1:0]     tstamp
  );
    logic [LOG_W-1:0] e;
    e = '0;
    e[LOG_FLSTAT_LSB +: LOG_FLSTAT_W] = flstat;
    e[LOG_BROWNOUT_BIT]               = brownout;
    e[LOG_WDFAIL_BIT]                 = wdfail;
    e[LOG_RSTOUT_BIT]                 = rstout;
    e[LOG_TS_LSB +: LOG_TS_W]         = tstamp;
    return e;
  endfunction

endpackage

// File: rtl/reset_supervisor_fault_log_fifo.sv
// rtl/reset_supervisor_fault_log_fifo.sv - fault-log FIFO with registered read data
// Full pushes are dropped and flagged sticky, unless a pop frees the slot in the same cycle.
module fault_log_fifo
  import reset_supervisor_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = LOG_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [WIDTH-1:0] rdata_q;
  logic             overflow_q;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty_o    = (wptr_q == rptr_q);
  assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full || do_pop);
  assign rdata_o    = rdata_q;
  assign overflow_o = overflow_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rdata_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop) begin
        rptr_q  <= rptr_q + 1'b1;
        rdata_q <= mem_q[rptr_q[AW-1:0]];
      end
      if (push_i && !do_push) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/reset_supervisor.sv
// rtl/reset_supervisor.sv - watchdog/brownout reset stretcher with escalation and fault log
// Edge detect, stretch FSM, consecutive-fault counter and timestamp; log storage is in fault_log_fifo.
module reset_supervisor
  import reset_supervisor_pkg::*;
#(
  parameter int STRETCH   = DEF_STRETCH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ESC_LIMIT = DEF_ESC_LIMIT,
  parameter int QUIET     = DEF_QUIET
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wdfail_i,
  input  logic [2:0]  flstat_i,
  input  logic        brownout_i,
  input  logic        rstout_i,
  input  logic        rd_en_i,
  output logic [15:0] rd_data_o,
  output logic        empty_o,
  output logic        overflow_o,
  output logic        sysrst_o,
  output logic        safe_state_o,
  output logic [3:0]  fault_cnt_o
);

  localparam int SW = $clog2(STRETCH);
  localparam int QW = $clog2(QUIET);
  localparam logic [SW-1:0] STRETCH_RELOAD = SW'(STRETCH - 1);
  localparam logic [QW-1:0] QUIET_LAST     = QW'(QUIET - 1);
  localparam logic [3:0]    ESC_CNT        = 4'(ESC_LIMIT);

  sup_state_e          state_q, state_d;
  logic [SW-1:0]       stretch_q, stretch_d;
  logic [QW-1:0]       quiet_q, quiet_d;
  logic [3:0]          fault_cnt_q, fault_cnt_d;
  logic [LOG_TS_W-1:0] tstamp_q;
  logic                wdfail_q, brownout_q, rstout_q;
  logic                arm_q;
  logic                event_w;
  logic [LOG_W-1:0]    log_entry;

  // arm_q masks the first cycle after reset so a level already high is not an edge.
  assign event_w = arm_q && ((wdfail_i   && !wdfail_q)   ||
                             (brownout_i && !brownout_q) ||
                             (rstout_i   && !rstout_q));

  assign log_entry    = pack_entry(flstat_i, brownout_i, wdfail_i, rstout_i, tstamp_q);
  assign sysrst_o     = (state_q != ST_RUN);
  assign safe_state_o = (state_q == ST_SAFE);
  assign fault_cnt_o  = fault_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdfail_q   <= 1'b0;
      brownout_q <= 1'b0;
      rstout_q   <= 1'b0;
      arm_q      <= 1'b0;
      tstamp_q   <= '0;
    end else begin
      wdfail_q   <= wdfail_i;
      brownout_q <= brownout_i;
      rstout_q   <= rstout_i;
      arm_q      <= 1'b1;
      tstamp_q   <= tstamp_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      stretch_q   <= '0;
      quiet_q     <= '0;
      fault_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stretch_q   <= stretch_d;
      quiet_q     <= quiet_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stretch_d   = stretch_q;
    fault_cnt_d = fault_cnt_q;
    quiet_d     = '0;
    case (state_q)
      ST_RUN: begin
        if (event_w) begin
          state_d   = ST_ASSERT;
          stretch_d = STRETCH_RELOAD;
        end else if (quiet_q == QUIET_LAST) begin
          fault_cnt_d = '0;
        end else begin
          quiet_d = quiet_q + 1'b1;
        end
      end
      ST_ASSERT: begin
        if (event_w) begin
          stretch_d = STRETCH_RELOAD;
        end else if (stretch_q == '0) begin
          state_d = brownout_i ? ST_HOLD : ST_RUN;
        end else begin
          stretch_d = stretch_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (event_w || !brownout_i) begin
          state_d   = ST_ASSERT;
          stretch_d = STRETCH_RELOAD;
        end
      end
      default: ;
    endcase
    // Escalation overrides whatever transition the state logic chose.
    if (event_w && (state_q != ST_SAFE) && (fault_cnt_q != 4'hF)) begin
      fault_cnt_d = fault_cnt_q + 4'd1;
      if (fault_cnt_d == ESC_CNT) state_d = ST_SAFE;
    end
  end

  fault_log_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LOG_W)
  ) u_log (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (event_w),
    .wdata_i    (log_entry),
    .pop_i      (rd_en_i),
    .rdata_o    (rd_data_o),
    .empty_o    (empty_o),
    .overflow_o (overflow_o)
  );

endmodule

// File: tb/tb_reset_supervisor.sv
// tb/tb_reset_supervisor.sv - directed scoreboard bench for reset_supervisor
// Stimulus pushes expected log entries; a negedge monitor checks every pop.
module tb_reset_supervisor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wdfail = 1'b0;
  logic        brownout = 1'b0;
  logic        rstout = 1'b0;
  logic        rd_en = 1'b0;
  logic [2:0]  flstat = 3'd0;
  logic [15:0] rd_data;
  logic        empty, overflow, sysrst, safe_state;
  logic [3:0]  fault_cnt;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  logic [9:0]  tb_ts;
  bit          pend = 1'b0;

  always #5 clk = ~clk;

  reset_supervisor #(
    .STRETCH(16), .DEPTH(8), .ESC_LIMIT(3), .QUIET(64)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wdfail_i     (wdfail),
    .flstat_i     (flstat),
    .brownout_i   (brownout),
    .rstout_i     (rstout),
    .rd_en_i      (rd_en),
    .rd_data_o    (rd_data),
    .empty_o      (empty),
    .overflow_o   (overflow),
    .sysrst_o     (sysrst),
    .safe_state_o (safe_state),
    .fault_cnt_o  (fault_cnt)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 10'd1;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_pop: got rd_data 0x%0h with no expected entry", rd_data);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
    pend = !rst && rd_en && !empty;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wdfail = 1'b0; brownout = 1'b0; rstout = 1'b0; rd_en = 1'b0; flstat = 3'd0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic push_exp(input logic [2:0] fl, input logic bo, input logic wd, input logic ro);
    if (exp_q.size() < 8) exp_q.push_back({fl, bo, wd, ro, tb_ts});
  endtask

  task automatic pulse(input logic wd, input logic bo, input logic ro, input logic [2:0] fl);
    flstat = fl; wdfail = wd; brownout = bo; rstout = ro;
    push_exp(fl, bo, wd, ro);
    tick();
    wdfail = 1'b0; brownout = 1'b0; rstout = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (sysrst && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit ok;

    // single watchdog fail at timestamp 5
    do_reset();
    check("rst_sysrst", sysrst, 0);
    check("rst_safe", safe_state, 0);
    check("rst_cnt", fault_cnt, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_empty", empty, 1);
    n = 0;
    while (tb_ts != 10'd5 && n < 50) begin n++; tick(); end
    flstat = 3'b001; wdfail = 1'b1;
    exp_q.push_back(16'h2805);  // WDFAIL occupies bit 11 of the entry
    check("t1_evt_cycle_sysrst", sysrst, 0);
    tick();
    wdfail = 1'b0;
    count_high(n);
    check("t1_stretch_len", n, 16);
    check("t1_cnt", fault_cnt, 1);
    check("t1_not_empty", empty, 0);
    pop();
    check("t1_empty_after_pop", empty, 1);
    pop();
    check("t1_rd_hold_on_empty", rd_data, 16'h2805);

    // long brownout: held through HOLD, then a fresh stretch
    do_reset();
    brownout = 1'b1; flstat = 3'd0;
    push_exp(3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    ok = 1'b1;
    for (int i = 1; i < 40; i++) begin
      if (!sysrst) ok = 1'b0;
      tick();
    end
    check("t2_sysrst_during_bo", ok, 1);
    brownout = 1'b0;
    tick();
    count_high(n);
    check("t2_tail_len", n, 16);
    check("t2_cnt", fault_cnt, 1);
    pop();

    // escalation to SAFE, then frozen count
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pulse(1'b0, 1'b0, 1'b1, 3'(k + 2));
      repeat (9) tick();
    end
    check("t3_safe", safe_state, 1);
    check("t3_cnt", fault_cnt, 3);
    check("t3_sysrst", sysrst, 1);
    pulse(1'b0, 1'b0, 1'b1, 3'b101);
    repeat (50) tick();
    check("t3_cnt_frozen", fault_cnt, 3);
    check("t3_safe_held", safe_state, 1);
    check("t3_sysrst_held", sysrst, 1);
    repeat (4) pop();
    check("t3_empty", empty, 1);

    // quiet period clears the consecutive count
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 3'd2);
    check("t4_cnt_first", fault_cnt, 1);
    repeat (98) tick();
    check("t4_cnt_quiet", fault_cnt, 0);
    tick();
    pulse(1'b1, 1'b0, 1'b0, 3'd4);
    check("t4_cnt_second", fault_cnt, 1);
    repeat (2) pop();

    // overflow, ordering, and push+pop while full
    do_reset();
    for (int k = 0; k < 9; k++) begin
      pulse(1'b1, 1'b0, 1'b0, 3'(k));
      repeat (2) tick();
    end
    check("t5_ovf", overflow, 1);
    check("t5_not_empty", empty, 0);
    repeat (8) pop();
    check("t5_empty", empty, 1);
    check("t5_ovf_sticky", overflow, 1);
    check("t5_sb_drained", exp_q.size(), 0);
    for (int k = 0; k < 8; k++) begin
      pulse(1'b0, 1'b0, 1'b1, 3'(7 - k));
      tick();
    end
    rd_en = 1'b1; wdfail = 1'b1; flstat = 3'd6;
    exp_q.push_back({3'd6, 1'b0, 1'b1, 1'b0, tb_ts});
    tick();
    rd_en = 1'b0; wdfail = 1'b0;
    tick();
    repeat (8) pop();
    check("t5_full_pushpop_empty", empty, 1);
    check("t5_full_pushpop_sb", exp_q.size(), 0);
    check("t5_rd_data_nonzero", (rd_data != 16'd0), 1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_safe", safe_state, 0);
    check("t5_rst_sysrst", sysrst, 0);
    check("t5_rst_ovf", overflow, 0);
    check("t5_rst_rd_data", rd_data, 0);

    // reset mid-pulse with input held high across release
    do_reset();
    flstat = 3'd1; wdfail = 1'b1;
    tick();
    repeat (6) tick();
    check("t6_sysrst_mid", sysrst, 1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_sysrst", sysrst, 0);
    check("t6_rst_cnt", fault_cnt, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_rd_data", rd_data, 0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    repeat (30) tick();
    check("t6_no_trigger_sysrst", sysrst, 0);
    check("t6_no_trigger_cnt", fault_cnt, 0);
    check("t6_no_trigger_empty", empty, 1);
    wdfail = 1'b0;
    tick();
    pulse(1'b1, 1'b0, 1'b0, 3'd2);
    check("t6_retrigger", sysrst, 1);
    check("t6_retrigger_cnt", fault_cnt, 1);
    pop();
    check("t6_sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
